// File: rtl/cache_arb_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : cache_arb_pkg                                                    |
// | Brief    : Shared types and default widths for the cacheline arbiter.       |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
package cache_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int LINE_W_DEF = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  typedef enum logic [0:0] {
    CLIENT_I = 1'b0,
    CLIENT_D = 1'b1
  } client_t;

endpackage
`default_nettype wire

// File: rtl/cacheline_arbiter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : cacheline_arbiter_if                                             |
// | Brief    : icache/dcache miss ports plus the adaptor-side line port.        |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
interface cacheline_arbiter_if
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) ();

  logic [ADDR_W-1:0] i_address_i;
  logic              i_read_i;
  logic [LINE_W-1:0] i_line_o;
  logic              i_resp_o;

  logic [ADDR_W-1:0] d_address_i;
  logic              d_read_i;
  logic              d_write_i;
  logic [LINE_W-1:0] d_line_i;
  logic [LINE_W-1:0] d_line_o;
  logic              d_resp_o;

  logic [ADDR_W-1:0] address_o;
  logic [LINE_W-1:0] line_o;
  logic              read_o;
  logic              write_o;
  logic [LINE_W-1:0] line_i;
  logic              resp_i;

  // Arbiter side
  modport slave (
    input  i_address_i, i_read_i, d_address_i, d_read_i, d_write_i, d_line_i,
    input  line_i, resp_i,
    output i_line_o, i_resp_o, d_line_o, d_resp_o,
    output address_o, line_o, read_o, write_o
  );

  // Environment side: clients plus adaptor
  modport master (
    output i_address_i, i_read_i, d_address_i, d_read_i, d_write_i, d_line_i,
    output line_i, resp_i,
    input  i_line_o, i_resp_o, d_line_o, d_resp_o,
    input  address_o, line_o, read_o, write_o
  );

endinterface
`default_nettype wire

// File: rtl/cache_arb_select.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : cache_arb_select                                                 |
// | Brief    : Winner selection; CACHE_ARB_ROUND_ROBIN_EN adds a last-grant     |
// |            flop, otherwise dcache has fixed priority.                       |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module cache_arb_select
  import cache_arb_pkg::*;
(
  input  logic    clk,
  input  logic    reset_n,
  input  logic    i_icache_req,
  input  logic    i_dcache_req,
  input  logic    i_take,
  output client_t o_winner
);

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  client_t r_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last <= CLIENT_I;
    end else if (i_take) begin
      r_last <= o_winner;
    end
  end

  // On a tie the client that was not granted last time wins.
  always_comb begin
    o_winner = CLIENT_I;
    if (i_icache_req && i_dcache_req) begin
      o_winner = (r_last == CLIENT_I) ? CLIENT_D : CLIENT_I;
    end else if (i_dcache_req) begin
      o_winner = CLIENT_D;
    end
  end
`else
  logic w_unused_ok;
  assign w_unused_ok = ^{clk, reset_n, i_take, i_icache_req};

  always_comb begin
    o_winner = i_dcache_req ? CLIENT_D : CLIENT_I;
  end
`endif

endmodule
`default_nettype wire

// File: rtl/cacheline_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : cacheline_arbiter                                                |
// | Brief    : Merges icache/dcache miss ports onto one adaptor line port.      |
// |            Define CACHE_ARB_ROUND_ROBIN_EN for round-robin tie breaking.    |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module cacheline_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  cacheline_arbiter_if.slave  bus
);

  arb_state_t        r_state;
  logic [ADDR_W-1:0] r_address;
  logic [LINE_W-1:0] r_line;
  logic              r_read;
  logic              r_write;
  logic [LINE_W-1:0] r_i_line;
  logic [LINE_W-1:0] r_d_line;
  logic              r_i_resp;
  logic              r_d_resp;

  client_t w_winner;
  logic    w_d_req;
  logic    w_any_req;
  logic    w_take;

  assign w_d_req   = bus.d_read_i | bus.d_write_i;
  assign w_any_req = bus.i_read_i | w_d_req;
  assign w_take    = (r_state == IDLE) && w_any_req;

  cache_arb_select u_select (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_icache_req (bus.i_read_i),
    .i_dcache_req (w_d_req),
    .i_take       (w_take),
    .o_winner     (w_winner)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_address <= '0;
      r_line    <= '0;
      r_read    <= 1'b0;
      r_write   <= 1'b0;
      r_i_line  <= '0;
      r_d_line  <= '0;
      r_i_resp  <= 1'b0;
      r_d_resp  <= 1'b0;
    end else begin
      r_i_resp <= 1'b0;
      r_d_resp <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            if (w_winner == CLIENT_D) begin
              // Read and write together is a protocol error; the write wins.
              r_address <= bus.d_address_i;
              r_line    <= bus.d_line_i;
              r_write   <= bus.d_write_i;
              r_read    <= ~bus.d_write_i;
              r_state   <= SERVE_D;
            end else begin
              r_address <= bus.i_address_i;
              r_write   <= 1'b0;
              r_read    <= 1'b1;
              r_state   <= SERVE_I;
            end
          end
        end
        SERVE_I: begin
          if (bus.resp_i) begin
            r_i_line <= bus.line_i;
            r_read   <= 1'b0;
            r_write  <= 1'b0;
            r_i_resp <= 1'b1;
            r_state  <= DONE;
          end
        end
        SERVE_D: begin
          if (bus.resp_i) begin
            if (r_read) begin
              r_d_line <= bus.line_i;
            end
            r_read   <= 1'b0;
            r_write  <= 1'b0;
            r_d_resp <= 1'b1;
            r_state  <= DONE;
          end
        end
        // Requests are ignored here so a completing client can deassert.
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.address_o = r_address;
  assign bus.line_o    = r_line;
  assign bus.read_o    = r_read;
  assign bus.write_o   = r_write;
  assign bus.i_line_o  = r_i_line;
  assign bus.i_resp_o  = r_i_resp;
  assign bus.d_line_o  = r_d_line;
  assign bus.d_resp_o  = r_d_resp;

endmodule
`default_nettype wire

// File: doc/cacheline_arbiter.md
Name: cacheline_arbiter

Overview:
- Two-client arbiter directly upstream of the cacheline adaptor.
- Merges the instruction-cache miss port (read-only) and the data-cache miss port (read/write) onto the adaptor's single LLC-side line port.
- Registers the granted request, holds it stable until the adaptor responds, then returns read data and a one-cycle response to the granted client only.

Parameters:
- ADDR_W, 32, address width on all ports.
- LINE_W, 256, cache line width in bits.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- i_address_i  in  ADDR_W  icache miss address
- i_read_i  in  1  icache line read request, level, held until i_resp_o
- i_line_o  out  LINE_W  line returned to icache
- i_resp_o  out  1  icache completion, one-cycle pulse
- d_address_i  in  ADDR_W  dcache miss/writeback address
- d_read_i  in  1  dcache read request, level
- d_write_i  in  1  dcache writeback request, level
- d_line_i  in  LINE_W  dcache writeback data
- d_line_o  out  LINE_W  line returned to dcache
- d_resp_o  out  1  dcache completion, one-cycle pulse
- address_o  out  ADDR_W  to adaptor address_i
- line_o  out  LINE_W  to adaptor line_i
- read_o  out  1  to adaptor read_i
- write_o  out  1  to adaptor write_i
- line_i  in  LINE_W  from adaptor line_o
- resp_i  in  1  from adaptor resp_o

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0, including address_o, line_o, i_line_o and d_line_o. Reset mid-transaction abandons the transaction silently and issues no client resp.
- State machine has four states: IDLE, SERVE_I, SERVE_D, DONE.
- IDLE:
  - When any request is seen in cycle N, the winner's address, op and write data are latched.
  - read_o/write_o assert from cycle N+1 (registered).
  - Go to SERVE_I or SERVE_D.
- Priority: fixed, dcache over icache (see Optional Feature).
- d_read_i and d_write_i both high is a protocol error and is treated as a write.
- SERVE_x:
  - address_o, line_o, read_o and write_o stay constant, regardless of changes on the client inputs.
  - On resp_i=1 in cycle M:
    - capture line_i into x_line_o (read only; a write leaves x_line_o unchanged);
    - drop read_o/write_o;
    - pulse x_resp_o in cycle M+1;
    - go to DONE.
- DONE:
  - Lasts exactly one cycle (the cycle x_resp_o=1), then returns to IDLE.
  - Requests are ignored during DONE, so the completing client has one cycle to deassert and no double-issue occurs.
  - This also gives the adaptor its return cycle to idle.
- x_line_o holds its value until the next read completion for that client.
- The other client's resp is never asserted.
- Turnaround: minimum back-to-back issue is IDLE → SERVE → DONE → IDLE → SERVE, i.e. one idle cycle between transactions.
- resp_i outside SERVE_x is ignored.
- Requests deasserted mid-SERVE are ignored; the transaction completes and still pulses resp.

Optional Feature:
- Macro: CACHE_ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last-grant register, reset to icache, selects the winner on simultaneous requests.
  - The client not granted last wins.
  - Single requesters win unconditionally.
- Undefined: fixed dcache priority; no last-grant register is built.

Decomposition:
- Package cache_arb_pkg:
  - state enum arb_state_t {IDLE, SERVE_I, SERVE_D, DONE};
  - client enum client_t {CLIENT_I, CLIENT_D};
  - localparams ADDR_W_DEF=32, LINE_W_DEF=256.
- The arbiter is a single module.
- Natural sub-module: cache_arb_select (combinational winner selection plus the optional last-grant flop), so the priority policy is swappable and unit-testable.

Test Plan:
- Single icache read:
  - Stimulus: i_read_i=1 with address 0x0000_1000; adaptor returns resp_i after 6 cycles with line_i = 256'hA5…A5.
  - Expected: address_o=0x1000 and read_o=1 one cycle after the request; i_line_o=A5…A5 with i_resp_o pulsed exactly one cycle; d_resp_o stays 0.
- dcache writeback:
  - Stimulus: d_write_i=1, address 0x2000, d_line_i = 256'h0123…; d_line_i is changed while in SERVE_D.
  - Expected: line_o keeps the original 256'h0123… and write_o=1 until resp_i; d_resp_o pulses; d_line_o unchanged.
- Simultaneous i_read_i and d_read_i (addresses 0x100 and 0x200), both held:
  - Default build: dcache served first, icache next; at least one idle cycle between the two read_o assertions.
  - With CACHE_ARB_ROUND_ROBIN_EN: icache is first after reset is not granted on the first tie only if last-grant=icache, so dcache first, then icache; a repeated tie alternates.
- Reset mid-transaction:
  - Stimulus: reset_n asserted low during SERVE_D.
  - Expected: all outputs 0 asynchronously; after release, IDLE; no resp pulse.
- Protocol error and stray response:
  - Stimulus: d_read_i=d_write_i=1 → expect write_o=1, read_o=0. Separately, resp_i pulsed in IDLE.
  - Expected: the stray resp_i produces no client resp.
- Requester holds request through DONE:
  - Expected: exactly one transaction is issued, not two.
